// File: rtl/seq_mul_ctrl.sv
// Shift-add unsigned multiplier: one ripple-carry adder reused over N iterations
// to build a 2N-bit product, with a start/ready/done handshake.

module rca #(
    parameter int unsigned n = 4
) (
    input  logic [n-1:0] a_i,
    input  logic [n-1:0] b_i,
    output logic [n-1:0] sum_o
);

    always_comb begin
        logic carry;
        sum_o = '0;
        carry = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
    end

endmodule

module seq_mul_ctrl #(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int unsigned    CW   = $clog2(N + 1);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [N-1:0]   m_q, m_d;
    logic [N:0]     acc_q, acc_d;
    logic [N-1:0]   q_q, q_d;
    logic [2*N-1:0] prod_q, prod_d;

    logic [N:0] sum;
    logic [N:0] s;

    rca #(.n(N + 1)) u_rca (
        .a_i   ({1'b0, acc_q[N-1:0]}),
        .b_i   ({1'b0, m_q}),
        .sum_o (sum)
    );

    // acc_q[N] is only ever loaded with 0, so acc_q equals {1'b0, acc_q[N-1:0]}
    assign s = q_q[0] ? sum : acc_q;

    assign ready   = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = prod_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        prod_d  = prod_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d   = {1'b0, s[N:1]};
                q_d     = {s[0], q_q[N-1:1]};
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    state_d = S_DONE;
                    prod_d  = {acc_d[N-1:0], q_d};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            prod_q  <= prod_d;
        end
    end

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Scoreboard bench for seq_mul_ctrl: an 8-bit instance for directed scenarios
// and a 4-bit instance swept over every operand pair.

module tb_seq_mul_ctrl;

    typedef struct {
        longint p;
        longint t;
    } sb_t;

    logic        clk;
    logic        rst8_n, start8, ready8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;
    logic        rst4_n, start4, ready4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  product4;

    int checks = 0;
    int errors = 0;

    sb_t    q8[$];
    sb_t    q4[$];
    int     m8_st = 0, m8_cnt = 0, m4_st = 0, m4_cnt = 0;
    longint m8_prod = 0, m4_prod = 0, cyc8 = 0, cyc4 = 0;

    seq_mul_ctrl #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .start(start8), .a(a8), .b(b8),
        .ready(ready8), .busy(busy8), .done(done8), .product(product8)
    );

    seq_mul_ctrl #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .start(start4), .a(a4), .b(b4),
        .ready(ready4), .busy(busy4), .done(done4), .product(product4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: checks outputs for the current state, then advances on the
    // inputs the DUT will sample at the coming rising edge.
    always @(negedge clk) begin
        if (!rst8_n) begin
            m8_st = 0; m8_cnt = 0; m8_prod = 0;
            q8.delete();
        end
        cyc8++;
        chk("ready8", ready8, (m8_st != 1));
        chk("busy8", busy8, (m8_st == 1));
        chk("done8", done8, (m8_st == 2));
        if (m8_st == 2) begin
            sb_t e;
            e = q8.pop_front();
            chk("product8", product8, e.p);
            chk("latency8", cyc8 - e.t, 9);
            m8_prod = e.p;
        end else begin
            chk("hold8", product8, m8_prod);
        end
        if (rst8_n) begin
            case (m8_st)
                0, 2: if (start8) begin
                    q8.push_back('{longint'(a8) * longint'(b8), cyc8});
                    m8_st = 1; m8_cnt = 0;
                end else m8_st = 0;
                default: begin
                    if (m8_cnt == 7) m8_st = 2;
                    m8_cnt++;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst4_n) begin
            m4_st = 0; m4_cnt = 0; m4_prod = 0;
            q4.delete();
        end
        cyc4++;
        chk("ready4", ready4, (m4_st != 1));
        chk("busy4", busy4, (m4_st == 1));
        chk("done4", done4, (m4_st == 2));
        if (m4_st == 2) begin
            sb_t e;
            e = q4.pop_front();
            chk("product4", product4, e.p);
            chk("latency4", cyc4 - e.t, 5);
            m4_prod = e.p;
        end else begin
            chk("hold4", product4, m4_prod);
        end
        if (rst4_n) begin
            case (m4_st)
                0, 2: if (start4) begin
                    q4.push_back('{longint'(a4) * longint'(b4), cyc4});
                    m4_st = 1; m4_cnt = 0;
                end else m4_st = 0;
                default: begin
                    if (m4_cnt == 3) m4_st = 2;
                    m4_cnt++;
                end
            endcase
        end
    end

    task automatic op8(input logic [7:0] av, input logic [7:0] bv);
        @(posedge clk); #1;
        a8 = av; b8 = bv; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        repeat (9) @(posedge clk);
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv);
        @(posedge clk); #1;
        a4 = av; b4 = bv; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        repeat (5) @(posedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        rst8_n = 1'b0; rst4_n = 1'b0;
        start8 = 1'b0; start4 = 1'b0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0;
        #1;
        chk("rst_ready", ready8, 1);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_product", product8, 0);
        repeat (2) @(posedge clk);
        #1;
        rst8_n = 1'b1; rst4_n = 1'b1;

        op8(8'd13, 8'd11);
        op8(8'd255, 8'd255);
        op8(8'd0, 8'd200);
        op8(8'd1, 8'd1);

        // starts during RUN must be ignored
        @(posedge clk); #1;
        a8 = 8'd7; b8 = 8'd9; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        a8 = 8'd3; b8 = 8'd3; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (6) @(posedge clk);

        // back-to-back: DONE cycle doubles as accept cycle
        @(posedge clk); #1;
        a8 = 8'd20; b8 = 8'd30; start8 = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done8) begin
                found = 1;
                break;
            end
        end
        chk("b2b_done_seen", found, 1);
        a8 = 8'd5; b8 = 8'd6;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (9) @(posedge clk);

        // asynchronous reset mid-RUN aborts the operation
        @(posedge clk); #1;
        a8 = 8'd100; b8 = 8'd100; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst8_n = 1'b0;
        #1;
        chk("abort_busy", busy8, 0);
        chk("abort_ready", ready8, 1);
        chk("abort_done", done8, 0);
        chk("abort_product", product8, 0);
        repeat (2) @(posedge clk);
        #1;
        rst8_n = 1'b1;
        op8(8'd2, 8'd3);

        for (int unsigned x = 0; x < 16; x++)
            for (int unsigned y = 0; y < 16; y++)
                op4(4'(x), 4'(y));

        repeat (2) @(posedge clk);
        chk("sb8_drained", q8.size(), 0);
        chk("sb4_drained", q4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
